// File: rtl/data_mem_responder.sv
// Data-memory responder for the RV32I core: byte-lane RAM, fixed-latency load
// pipeline, and a 16-byte MMIO window with tohost/halt, console and counters.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS  = 4096,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
   parameter string       INIT_FILE    = ""
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   input  logic [3:0]  data_we,
   input  logic        data_re,
   output logic [31:0] data_rdata,
   output logic        rsp_valid,
   output logic        halt,
   output logic [31:0] halt_code,
   output logic        console_valid,
   output logic [7:0]  console_byte,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic [31:0]   r_cyclecnt;
   logic [31:0]   r_storecnt;
   logic [31:0]   r_halt_code;
   logic          r_halt;
   logic          r_err;
   logic          r_console_valid;
   logic [7:0]    r_console_byte;
   logic          r_pipe_v [READ_LATENCY];
   logic [31:0]   r_pipe_d [READ_LATENCY];

   logic          w_ram_hit;
   logic          w_mmio_hit;
   logic          w_store;
   logic [AW-1:0] w_idx;
   logic [1:0]    w_off;
   logic [31:0]   w_mmio_rdata;
   logic [31:0]   w_rdata;
   logic          w_unused;

   assign w_ram_hit  = ({2'b00, data_addr[31:2]} < DEPTH_WORDS);
   assign w_mmio_hit = (data_addr[31:4] == MMIO_BASE[31:4]);
   assign w_store    = |data_we;
   assign w_idx      = data_addr[2 +: AW];
   assign w_off      = data_addr[3:2];
   assign w_unused   = ^data_addr[1:0];

   always_comb begin
      w_mmio_rdata = 32'h0;
      case (w_off)
         2'd0:    w_mmio_rdata = r_halt_code;
         2'd2:    w_mmio_rdata = r_cyclecnt;
         2'd3:    w_mmio_rdata = r_storecnt;
         default: w_mmio_rdata = 32'h0;
      endcase
   end

   always_comb begin
      w_rdata = 32'hDEAD_BEEF;
      if (w_ram_hit)
         w_rdata = r_mem[w_idx];
      else if (w_mmio_hit)
         w_rdata = w_mmio_rdata;
   end

   // RAM is never cleared by rst; stores presented during rst are dropped.
   always_ff @(posedge clk) begin
      if (!rst && w_store && w_ram_hit) begin
         for (int i = 0; i < 4; i++) begin
            if (data_we[i])
               r_mem[w_idx][8*i +: 8] <= data_wdata[8*i +: 8];
         end
      end
   end

   // Each stage only loads data when the stage before it is valid, so the last
   // stage holds the previous response while rsp_valid is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(READ_LATENCY); i++) begin
            r_pipe_v[i] <= 1'b0;
            r_pipe_d[i] <= 32'h0;
         end
      end else begin
         r_pipe_v[0] <= data_re;
         if (data_re)
            r_pipe_d[0] <= w_rdata;
         for (int i = 1; i < int'(READ_LATENCY); i++) begin
            r_pipe_v[i] <= r_pipe_v[i-1];
            if (r_pipe_v[i-1])
               r_pipe_d[i] <= r_pipe_d[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cyclecnt      <= 32'h0;
         r_storecnt      <= 32'h0;
         r_halt_code     <= 32'h0;
         r_halt          <= 1'b0;
         r_err           <= 1'b0;
         r_console_valid <= 1'b0;
         r_console_byte  <= 8'h0;
      end else begin
         r_cyclecnt      <= r_cyclecnt + 32'd1;
         r_console_valid <= 1'b0;
         if (w_store)
            r_storecnt <= r_storecnt + 32'd1;
         if (w_store && w_mmio_hit) begin
            if (w_off == 2'd0 && !r_halt && data_wdata != 32'h0) begin
               r_halt      <= 1'b1;
               r_halt_code <= data_wdata;
            end
            if (w_off == 2'd1 && data_we[0]) begin
               r_console_valid <= 1'b1;
               r_console_byte  <= data_wdata[7:0];
            end
         end
         if ((w_store || data_re) && !w_ram_hit && !w_mmio_hit)
            r_err <= 1'b1;
      end
   end

   assign data_rdata    = r_pipe_d[READ_LATENCY-1];
   assign rsp_valid     = r_pipe_v[READ_LATENCY-1];
   assign halt          = r_halt;
   assign halt_code     = r_halt_code;
   assign console_valid = r_console_valid;
   assign console_byte  = r_console_byte;
   assign err           = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (latency 1, 2, 3) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_data_mem_responder;

   localparam logic [31:0] BASE = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  we_i = '0;
   logic        re_i = 1'b0;

   logic        rsp_valid_w [3];
   logic [31:0] rdata_w [3];
   logic        halt_w [3];
   logic [31:0] halt_code_w [3];
   logic        cv_w [3];
   logic [7:0]  cb_w [3];
   logic        err_w [3];

   int n_cmp = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      data_mem_responder #(
         .DEPTH_WORDS(4096), .READ_LATENCY(g + 1), .MMIO_BASE(BASE), .INIT_FILE("")
      ) u_dut (
         .clk(clk), .rst(rst), .data_addr(addr), .data_wdata(wdata),
         .data_we(we_i), .data_re(re_i),
         .data_rdata(rdata_w[g]), .rsp_valid(rsp_valid_w[g]),
         .halt(halt_w[g]), .halt_code(halt_code_w[g]),
         .console_valid(cv_w[g]), .console_byte(cb_w[g]), .err(err_w[g])
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_mem [64];
   logic [31:0] m_code = '0, m_cyc = '0, m_scnt = '0;
   logic        m_halt = 1'b0, m_err = 1'b0, m_cv = 1'b0;
   logic [7:0]  m_cb = '0;
   logic        ld_v [8];
   logic [31:0] ld_d [8];
   logic        exp_v [3];
   logic [31:0] exp_d [3];
   int          n_edge = 0;

   initial begin
      for (int i = 0; i < 8; i++) begin ld_v[i] = 1'b0; ld_d[i] = '0; end
      for (int k = 0; k < 3; k++) begin exp_v[k] = 1'b0; exp_d[k] = '0; end
   end

   // A load sampled at edge n is seen by the latency-L instance after edge n+L-1.
   always @(posedge clk) begin
      logic        is_ram, is_mmio;
      logic [31:0] rv;
      n_edge++;
      if (rst) begin
         for (int i = 0; i < 8; i++) ld_v[i] = 1'b0;
         m_code = '0; m_cyc = '0; m_scnt = '0;
         m_halt = 1'b0; m_err = 1'b0; m_cv = 1'b0; m_cb = '0;
         for (int k = 0; k < 3; k++) begin exp_v[k] = 1'b0; exp_d[k] = '0; end
      end else begin
         is_ram  = (addr[31:2] < 30'd4096);
         is_mmio = (addr[31:4] == BASE[31:4]);
         if (is_ram)               rv = m_mem[addr[7:2]];
         else if (!is_mmio)        rv = 32'hDEAD_BEEF;
         else if (addr[3:2] == 0)  rv = m_code;
         else if (addr[3:2] == 2)  rv = m_cyc;
         else if (addr[3:2] == 3)  rv = m_scnt;
         else                      rv = 32'h0;
         ld_v[n_edge % 8] = re_i;
         ld_d[n_edge % 8] = rv;
         m_cv = 1'b0;
         if (we_i != 0) begin
            m_scnt = m_scnt + 1;
            if (is_ram) begin
               for (int b = 0; b < 4; b++)
                  if (we_i[b]) m_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
            end else if (is_mmio) begin
               if (addr[3:2] == 0 && !m_halt && wdata != 0) begin
                  m_halt = 1'b1; m_code = wdata;
               end
               if (addr[3:2] == 1 && we_i[0]) begin
                  m_cv = 1'b1; m_cb = wdata[7:0];
               end
            end else m_err = 1'b1;
         end
         if (re_i && !is_ram && !is_mmio) m_err = 1'b1;
         m_cyc = m_cyc + 1;
         for (int k = 0; k < 3; k++) begin
            if (n_edge - k >= 0 && ld_v[(n_edge - k) % 8]) begin
               exp_v[k] = 1'b1;
               exp_d[k] = ld_d[(n_edge - k) % 8];
            end else exp_v[k] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("L%0d_rsp_valid", k + 1), 32'(rsp_valid_w[k]), 32'(exp_v[k]));
            chk($sformatf("L%0d_data_rdata", k + 1), rdata_w[k], exp_d[k]);
            chk($sformatf("L%0d_halt", k + 1), 32'(halt_w[k]), 32'(m_halt));
            chk($sformatf("L%0d_halt_code", k + 1), halt_code_w[k], m_code);
            chk($sformatf("L%0d_err", k + 1), 32'(err_w[k]), 32'(m_err));
            chk($sformatf("L%0d_console_valid", k + 1), 32'(cv_w[k]), 32'(m_cv));
            chk($sformatf("L%0d_console_byte", k + 1), 32'(cb_w[k]), 32'(m_cb));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] we, input logic re);
      addr = a; wdata = wd; we_i = we; re_i = re;
      @(posedge clk); #1;
      addr = '0; wdata = '0; we_i = '0; re_i = 1'b0;
   endtask

   task automatic expect_load(input string nm, input logic [31:0] a, input logic [31:0] exp);
      bit got = 1'b0;
      drive(a, 32'h0, 4'h0, 1'b1);
      for (int k = 0; k < 4 && !got; k++) begin
         @(negedge clk);
         if (rsp_valid_w[0]) begin
            got = 1'b1;
            chk(nm, rdata_w[0], exp);
         end
      end
      if (!got) chk({nm, "_timeout"}, 32'h0, 32'h1);
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a;
      logic [3:0]  w;
      int          r;

      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("reset_rsp_valid", 32'(rsp_valid_w[0]), 32'h0);
      chk("reset_data_rdata", rdata_w[0], 32'h0);
      chk("reset_halt", 32'(halt_w[0]), 32'h0);
      chk("reset_halt_code", halt_code_w[0], 32'h0);
      chk("reset_err", 32'(err_w[0]), 32'h0);
      chk("reset_console_valid", 32'(cv_w[0]), 32'h0);
      chk("reset_console_byte", 32'(cb_w[0]), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 64; i++)
         drive(32'(i * 4), 32'hA5A5_0000 + 32'(i), 4'hF, 1'b0);

      drive(32'h10, 32'h1122_3344, 4'hF, 1'b0);
      drive(32'h10, 32'h0000_AA00, 4'b0010, 1'b0);
      expect_load("lane_store", 32'h10, 32'h1122_AA44);

      drive(32'h0, 32'h0, 4'h0, 1'b1);
      drive(32'h4, 32'h0, 4'h0, 1'b1);
      drive(32'h8, 32'h0, 4'h0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("L3_burst_valid%0d", k), 32'(rsp_valid_w[2]), (k < 3) ? 32'h1 : 32'h0);
         if (k < 3) chk($sformatf("L3_burst_data%0d", k), rdata_w[2], 32'hA5A5_0000 + 32'(k));
      end
      @(posedge clk); #1;

      drive(32'h20, 32'h5, 4'hF, 1'b0);
      drive(32'h20, 32'h9, 4'hF, 1'b1);
      drive(32'h20, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      chk("rw_same_cycle_old", rdata_w[1], 32'h5);
      @(negedge clk);
      chk("rw_next_cycle_new", rdata_w[1], 32'h9);
      @(posedge clk); #1;
      expect_load("storecnt_68", BASE + 32'hC, 32'd68);

      drive(BASE, 32'h1, 4'hF, 1'b0);
      @(negedge clk);
      chk("halt_set", 32'(halt_w[0]), 32'h1);
      chk("halt_code_1", halt_code_w[0], 32'h1);
      @(posedge clk); #1;
      drive(BASE, 32'h7, 4'hF, 1'b0);
      @(negedge clk);
      chk("halt_code_kept", halt_code_w[0], 32'h1);
      @(posedge clk); #1;
      drive(BASE + 32'h4, 32'h41, 4'b0001, 1'b0);
      @(negedge clk);
      chk("console_pulse", 32'(cv_w[0]), 32'h1);
      chk("console_byte", 32'(cb_w[0]), 32'h41);
      @(negedge clk);
      chk("console_pulse_end", 32'(cv_w[0]), 32'h0);
      @(posedge clk); #1;

      expect_load("err_load", 32'h8000_0000, 32'hDEAD_BEEF);
      chk("err_set", 32'(err_w[0]), 32'h1);
      drive(32'h8000_0000, 32'h1234_5678, 4'hF, 1'b0);
      expect_load("err_store_dropped", 32'h0, 32'hA5A5_0000);
      chk("err_sticky", 32'(err_w[0]), 32'h1);
      expect_load("storecnt_72", BASE + 32'hC, 32'd72);

      for (int it = 0; it < 2000; it++) begin
         r = int'($urandom_range(0, 99));
         w = ($urandom_range(0, 9) < 4) ? 4'($urandom_range(1, 15)) : 4'h0;
         if (r < 70) begin
            if (w != 0) a = {24'h0, 6'($urandom_range(16, 63)), 2'($urandom_range(0, 3))};
            else        a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
         end else if (r < 85) a = {BASE[31:4], 4'($urandom_range(0, 15))};
         else a = {1'b1, 31'($urandom)};
         drive(a, $urandom, w, 1'($urandom_range(0, 1)));
      end

      drive(32'h10, 32'h0, 4'h0, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_discard_L2", 32'(rsp_valid_w[1]), 32'h0);
      chk("rst_discard_L3", 32'(rsp_valid_w[2]), 32'h0);
      chk("rst_rdata_L2", rdata_w[1], 32'h0);
      chk("rst_halt", 32'(halt_w[0]), 32'h0);
      chk("rst_err", 32'(err_w[0]), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      expect_load("cyclecnt_after_rst", BASE + 32'h8, 32'h0);
      expect_load("ram_survives_rst", 32'h10, 32'h1122_AA44);
      expect_load("storecnt_after_rst", BASE + 32'hC, 32'h0);

      repeat (4) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
